uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit-side companion to the board's UART port group: buffers bytes produced by application logic in a small FIFO and hands them one at a time to the on-board UART transmitter through the `txdata` / `txclk` / `txready` handshake. Sits between user logic in `top` and the `txdata`, `txclk` and `txready` top-level ports, mirroring the receive path that consumes `rxdata` / `rxclk` / `rxready`. All state runs on the 100 Hz board clock.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; must be a power of two, ≥ 2.
- `GUARD_MAX`, 4: maximum cycles spent waiting for `txready` to fall after a strobe.

Ports:
- `hz100`  in  1  system clock; one clock domain for the block.
- `reset`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  push request for `wr_data`.
- `wr_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a push was dropped because FIFO was full.
- `txdata`  out  8  byte presented to the UART.
- `txclk`  out  1  one-cycle strobe; UART latches `txdata` while high.
- `txready`  in  1  UART can accept a byte.

## Operation
- Reset values: `full`=0, `empty`=1, `count`=0, `overflow`=0, `txdata`=8'h00, `txclk`=0, state `TX_IDLE`, both pointers 0. Reset mid-transfer discards queued bytes and drops `txclk` at the next edge.
- Push: on an edge with `wr_en`=1 and `full`=0, `wr_data` is written at the write pointer, and the pointer and `count` increment. With `full`=1 the byte is dropped and `overflow` is set; it stays set until reset.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `full`/`empty` are derived from `count` and are registered.
- Simultaneous push and pop: both take effect and `count` is unchanged. When full, a push is still rejected even if a pop occurs in the same cycle, because `full` is evaluated from the current-cycle registered value.
- The FSM has three states:
  - `TX_IDLE`: if `empty`=0 and `txready`=1, load `txdata` with the head byte, set `txclk`=1, pop (advance read pointer), and go to `TX_STROBE`. Otherwise stay.
  - `TX_STROBE`: clear `txclk` and go to `TX_GUARD`. The guard counter clears.
  - `TX_GUARD`: go to `TX_IDLE` when `txready`=0, or when the guard counter reaches `GUARD_MAX`-1; otherwise increment the counter. This prevents re-strobing before the UART has registered the previous byte.
- `txdata` holds the last sent byte between strobes and never changes while `txclk`=1.
- `txready` is ignored outside `TX_IDLE` and `TX_GUARD`.

## Timing
- `txclk` is registered and high for exactly one cycle per byte.
- Latency: a byte pushed at edge k into an empty FIFO, with the FSM in `TX_IDLE` and `txready`=1, produces `txclk`=1 from edge k+1 to edge k+2.
- Throughput: at most one byte every 3 cycles when `txready` falls immediately. The worst case is 2+`GUARD_MAX` cycles per byte when `txready` stays high.
- `count` decrements at the same edge that raises `txclk`.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_GUARD} tx_state_t`
  - byte type `uart_byte_t` (logic [7:0])
  - default `DEPTH` / `GUARD_MAX` constants, shared with the receive side.
- Sub-module `byte_fifo`: storage, pointers, `count`, `full`/`empty`, and overflow detection. `uart_tx_queue` instantiates it and contains only the handshake FSM and guard counter.

## Test plan
- Reset, then push 8'h41 with `txready`=1 → `txclk` high for one cycle, one cycle after the push edge, with `txdata`=8'h41; `count` returns to 0 and `empty`=1.
- Push 8'h48, 8'h49, 8'h21 back-to-back; `txready` falls the cycle after each strobe and rises 2 cycles later → three strobes in order 48, 49, 21, each separated by ≥3 cycles; no byte is repeated or lost.
- Hold `txready`=0 and push 9 bytes with `DEPTH`=8 → `full`=1 after 8 pushes, 9th byte dropped, `overflow`=1. Then raise `txready` → bytes 1–8 sent in order, and `overflow` stays 1.
- Fill to 7 entries, then push while a strobe pops in the same cycle → `count` remains 7, and FIFO order is preserved across pointer wrap.
- Hold `txready` stuck high with 2 bytes queued → strobes exactly 2+`GUARD_MAX` cycles apart (6 cycles with defaults).
- Assert `reset` during `TX_STROBE` with 3 bytes queued → next edge gives `txclk`=0, `count`=0, `empty`=1, `txdata`=8'h00; no further strobes are issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and default sizing for the transmit and receive queues.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_GUARD} tx_state_t;

    typedef logic [7:0] uart_byte_t;

    localparam int UART_DEPTH     = 8;
    localparam int UART_GUARD_MAX = 4;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Application-side push port plus the txdata/txclk/txready UART handshake.
interface uart_tx_queue_if
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH
);
    logic                     wr_en;
    uart_byte_t               wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    uart_byte_t               txdata;
    logic                     txclk;
    logic                     txready;

    // master is the surrounding environment: the byte producer and the UART.
    modport master (
        output wr_en, wr_data, txready,
        input  full, empty, count, overflow, txdata, txclk
    );

    modport slave (
        input  wr_en, wr_data, txready,
        output full, empty, count, overflow, txdata, txclk
    );
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count, registered full/empty and sticky overflow.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  uart_byte_t             wr_data,
    input  logic                   rd_en,
    output uart_byte_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);

    uart_byte_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_next;
    logic            push;
    logic            pop;

    // full is the registered value, so a pop in the same cycle cannot admit a push.
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + (AW+1)'(1);
        else if (!push && pop)
            count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_queue.sv
// Queues application bytes and strobes them one at a time into the UART.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_DEPTH,
    parameter int GUARD_MAX = UART_GUARD_MAX
) (
    input  logic            hz100,
    input  logic            reset,
    uart_tx_queue_if.slave  bus
);
    localparam int GW = (GUARD_MAX > 1) ? $clog2(GUARD_MAX) : 1;

    tx_state_t      state;
    logic [GW-1:0]  guard;
    uart_byte_t     head;
    logic           pop;

    assign pop = (state == TX_IDLE) && !bus.empty && bus.txready;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (hz100),
        .rst      (reset),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (bus.full),
        .empty    (bus.empty),
        .count    (bus.count),
        .overflow (bus.overflow)
    );

    // The guard state waits for txready to drop so the UART sees each byte once.
    always_ff @(posedge hz100) begin
        if (reset) begin
            state      <= TX_IDLE;
            guard      <= '0;
            bus.txdata <= '0;
            bus.txclk  <= 1'b0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        bus.txdata <= head;
                        bus.txclk  <= 1'b1;
                        state      <= TX_STROBE;
                    end
                end
                TX_STROBE: begin
                    bus.txclk <= 1'b0;
                    guard     <= '0;
                    state     <= TX_GUARD;
                end
                TX_GUARD: begin
                    if (!bus.txready || guard == GW'(GUARD_MAX - 1))
                        state <= TX_IDLE;
                    else
                        guard <= guard + GW'(1);
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed self-checking bench for uart_tx_queue with DEPTH=8, GUARD_MAX=4.
module tb_uart_tx_queue;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    uart_byte_t sq[$];
    int         sc[$];
    uart_byte_t pend[$];

    always #5 clk = ~clk;

    uart_tx_queue_if #(.DEPTH(8)) bus ();

    uart_tx_queue #(
        .DEPTH     (8),
        .GUARD_MAX (4)
    ) dut (
        .hz100 (clk),
        .reset (rst),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: byte and cycle stamp of every cycle with txclk high.
    always @(negedge clk) begin
        if (bus.txclk === 1'b1) begin
            sq.push_back(bus.txdata);
            sc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.txready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sq.delete();
        sc.delete();
    endtask

    // Each cycle: push the next pending byte, and optionally model a UART that
    // drops txready after a strobe and raises it again two cycles later.
    task automatic run(input int cycles, input bit react);
        int down;
        down = 0;
        for (int i = 0; i < cycles; i++) begin
            if (react) begin
                if (bus.txclk === 1'b1) begin
                    bus.txready = 1'b0;
                    down = 2;
                end else if (down > 0) begin
                    down--;
                    if (down == 0) bus.txready = 1'b1;
                end
            end
            if (pend.size() > 0) begin
                bus.wr_en = 1'b1;
                bus.wr_data = pend.pop_front();
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr_en = 1'b0;
        bus.wr_data = 8'hAA;
        bus.txready = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.txdata !== 8'h00) begin n_err++; $display("FAIL reset_txdata: got %h want 00", bus.txdata); end
        n_cmp++; if (bus.txclk !== 1'b0) begin n_err++; $display("FAIL reset_txclk: got %b want 0", bus.txclk); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        bus.txready = 1'b1;
        pend.push_back(8'h41);
        run(1, 1'b0);
        n_cmp++; if (bus.txclk !== 1'b0) begin n_err++; $display("FAIL single_no_early_strobe: got %b want 0", bus.txclk); end
        n_cmp++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL single_count_after_push: got %0d want 1", bus.count); end
        tick();
        n_cmp++; if (bus.txclk !== 1'b1) begin n_err++; $display("FAIL single_strobe: got %b want 1", bus.txclk); end
        n_cmp++; if (bus.txdata !== 8'h41) begin n_err++; $display("FAIL single_txdata: got %h want 41", bus.txdata); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL single_count_pop: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL single_empty: got %b want 1", bus.empty); end
        tick();
        n_cmp++; if (bus.txclk !== 1'b0) begin n_err++; $display("FAIL single_strobe_width: got %b want 0", bus.txclk); end
        n_cmp++; if (bus.txdata !== 8'h41) begin n_err++; $display("FAIL single_txdata_hold: got %h want 41", bus.txdata); end
        run(8, 1'b0);
        n_cmp++; if (sq.size() != 1) begin n_err++; $display("FAIL single_strobe_total: got %0d want 1", sq.size()); end
    endtask

    task automatic test_back_to_back();
        uart_byte_t exp [3];
        uart_byte_t got;
        exp[0] = 8'h48; exp[1] = 8'h49; exp[2] = 8'h21;
        apply_reset();
        bus.txready = 1'b1;
        pend.push_back(8'h48);
        pend.push_back(8'h49);
        pend.push_back(8'h21);
        run(20, 1'b1);
        n_cmp++; if (sq.size() != 3) begin n_err++; $display("FAIL b2b_strobe_total: got %0d want 3", sq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < sq.size()) ? sq[i] : 8'hxx;
            n_cmp++; if (got !== exp[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        for (int i = 1; i < 3; i++) begin
            if (i < sc.size()) begin
                n_cmp++; if (sc[i] - sc[i-1] != 3) begin n_err++; $display("FAIL b2b_gap%0d: got %0d want 3", i, sc[i] - sc[i-1]); end
            end
        end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_overflow();
        uart_byte_t got;
        uart_byte_t exp;
        apply_reset();
        bus.txready = 1'b0;
        for (int i = 0; i < 8; i++) pend.push_back(8'(8'h10 + i));
        run(8, 1'b0);
        n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", bus.full); end
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL ovf_count8: got %0d want 8", bus.count); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_not_yet: got %b want 0", bus.overflow); end
        pend.push_back(8'h18);
        run(1, 1'b0);
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL ovf_count_hold: got %0d want 8", bus.count); end
        bus.txready = 1'b1;
        run(40, 1'b1);
        n_cmp++; if (sq.size() != 8) begin n_err++; $display("FAIL ovf_strobe_total: got %0d want 8", sq.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < sq.size()) ? sq[i] : 8'hxx;
            exp = 8'(8'h10 + i);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL ovf_byte%0d: got %h want %h", i, got, exp); end
        end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL ovf_drained: got %b want 1", bus.empty); end
    endtask

    task automatic test_wrap_simul();
        uart_byte_t got;
        uart_byte_t exp;
        apply_reset();
        bus.txready = 1'b0;
        for (int i = 0; i < 5; i++) pend.push_back(8'(8'h50 + i));
        run(5, 1'b0);
        bus.txready = 1'b1;
        run(25, 1'b1);
        n_cmp++; if (sq.size() != 5) begin n_err++; $display("FAIL wrap_predrain: got %0d want 5", sq.size()); end
        bus.txready = 1'b0;
        for (int i = 0; i < 7; i++) pend.push_back(8'(8'h60 + i));
        run(7, 1'b0);
        n_cmp++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL wrap_count7: got %0d want 7", bus.count); end
        n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL wrap_not_full: got %b want 0", bus.full); end
        sq.delete();
        sc.delete();
        bus.txready = 1'b1;
        pend.push_back(8'h67);
        run(1, 1'b0);
        n_cmp++; if (bus.count !== 4'd7) begin n_err++; $display("FAIL simul_count: got %0d want 7", bus.count); end
        n_cmp++; if (bus.txclk !== 1'b1) begin n_err++; $display("FAIL simul_strobe: got %b want 1", bus.txclk); end
        n_cmp++; if (bus.txdata !== 8'h60) begin n_err++; $display("FAIL simul_txdata: got %h want 60", bus.txdata); end
        run(30, 1'b1);
        n_cmp++; if (sq.size() != 8) begin n_err++; $display("FAIL wrap_strobe_total: got %0d want 8", sq.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < sq.size()) ? sq[i] : 8'hxx;
            exp = 8'(8'h60 + i);
            n_cmp++; if (got !== exp) begin n_err++; $display("FAIL wrap_byte%0d: got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_stuck_high();
        apply_reset();
        bus.txready = 1'b0;
        pend.push_back(8'h70);
        pend.push_back(8'h71);
        run(2, 1'b0);
        bus.txready = 1'b1;
        run(20, 1'b0);
        n_cmp++; if (sq.size() != 2) begin n_err++; $display("FAIL stuck_strobe_total: got %0d want 2", sq.size()); end
        if (sq.size() >= 2) begin
            n_cmp++; if (sq[0] !== 8'h70) begin n_err++; $display("FAIL stuck_byte0: got %h want 70", sq[0]); end
            n_cmp++; if (sq[1] !== 8'h71) begin n_err++; $display("FAIL stuck_byte1: got %h want 71", sq[1]); end
            n_cmp++; if (sc[1] - sc[0] != 6) begin n_err++; $display("FAIL stuck_gap: got %0d want 6", sc[1] - sc[0]); end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.txready = 1'b0;
        for (int i = 0; i < 4; i++) pend.push_back(8'(8'h80 + i));
        run(4, 1'b0);
        bus.txready = 1'b1;
        run(1, 1'b0);
        n_cmp++; if (bus.txclk !== 1'b1) begin n_err++; $display("FAIL rmid_strobe: got %b want 1", bus.txclk); end
        n_cmp++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL rmid_count3: got %0d want 3", bus.count); end
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.txclk !== 1'b0) begin n_err++; $display("FAIL rmid_txclk: got %b want 0", bus.txclk); end
        n_cmp++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.txdata !== 8'h00) begin n_err++; $display("FAIL rmid_txdata: got %h want 00", bus.txdata); end
        rst = 1'b0;
        sq.delete();
        sc.delete();
        run(15, 1'b0);
        n_cmp++; if (sq.size() != 0) begin n_err++; $display("FAIL rmid_no_strobe: got %0d want 0", sq.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap_simul();
        test_stuck_high();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
